// File: rtl/ram_arbiter_pkg.sv
// Shared RAM types and arbiter state encoding.
// Word/byte geometry helpers for the single-port RAM.
package ram_arbiter_pkg;

  localparam int RAM_AW     = 12;
  localparam int WORD_W     = 32;
  localparam int WORD_BYTES = WORD_W / 8;
  localparam int OFF_W      = $clog2(WORD_BYTES);

  typedef logic [RAM_AW-1:0] RamAddress;
  typedef logic [WORD_W-1:0] Word;

  typedef enum logic {
    DATA_PRI  = 1'b0,
    INSTR_PRI = 1'b1
  } arb_state_e;

  function automatic logic is_aligned(RamAddress a);
    return a[OFF_W-1:0] == '0;
  endfunction

  function automatic logic [RAM_AW-OFF_W-1:0] word_addr(RamAddress a);
    return a[RAM_AW-1:OFF_W];
  endfunction

endpackage

// File: rtl/ram_arbiter.sv
// Two-port (data/fetch) arbiter in front of one single-port RAM.
// Data has priority; fetch is forced through after STARVE_LIMIT denials.
module ram_arbiter
  import ram_arbiter_pkg::*;
#(
  parameter int STARVE_LIMIT = 3
) (
  input  logic      clk,
  input  logic      rst_n,
  input  logic      d_req,
  input  logic      d_we,
  input  RamAddress d_addr,
  input  Word       d_wdata,
  output logic      d_gnt,
  output logic      d_rvalid,
  output Word       d_rdata,
  output logic      d_err,
  input  logic      i_req,
  input  RamAddress i_addr,
  output logic      i_gnt,
  output logic      i_rvalid,
  output Word       i_rdata,
  output logic      ram_we,
  output RamAddress ram_addr,
  output Word       ram_wdata,
  input  Word       ram_rdata
);

  localparam int CW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] LIM = CW'(STARVE_LIMIT);

  arb_state_e    r_state;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt_nxt;
  logic          w_i_win;
  logic          w_d_win;
  logic          w_d_mis;
  logic          r_d_rvalid;
  Word           r_d_rdata;
  logic          r_d_err;
  logic          r_i_rvalid;
  Word           r_i_rdata;

  assign w_d_mis = !is_aligned(d_addr);
  assign w_i_win = i_req && (!d_req || r_state == INSTR_PRI);
  assign w_d_win = d_req && !w_i_win;

  assign d_gnt = rst_n && w_d_win;
  assign i_gnt = rst_n && w_i_win;

  assign ram_we    = d_gnt && d_we && !w_d_mis;
  assign ram_wdata = d_wdata;
  assign ram_addr  = d_gnt ? d_addr :
                     i_gnt ? i_addr : '0;

  assign d_rvalid = r_d_rvalid;
  assign d_rdata  = r_d_rdata;
  assign d_err    = (d_gnt && d_we && w_d_mis) || r_d_err;
  assign i_rvalid = r_i_rvalid;
  assign i_rdata  = r_i_rdata;

  // Starvation count of consecutive denied fetch cycles (saturating)
  always_comb begin
    w_cnt_nxt = '0;
    if (i_req && !i_gnt)
      w_cnt_nxt = (r_cnt == LIM) ? LIM : r_cnt + 1'b1;
  end

  // Priority FSM and starvation counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= DATA_PRI;
      r_cnt   <= '0;
    end else begin
      r_cnt <= w_cnt_nxt;
      unique case (r_state)
        DATA_PRI:
          if (w_cnt_nxt == LIM) r_state <= INSTR_PRI;
        INSTR_PRI:
          if (i_gnt || !i_req) r_state <= DATA_PRI;
        default: r_state <= DATA_PRI;
      endcase
    end
  end

  // Data read return: capture RAM word (or 0 if misaligned) for one cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_d_rvalid <= 1'b0;
      r_d_rdata  <= '0;
      r_d_err    <= 1'b0;
    end else begin
      r_d_rvalid <= d_gnt && !d_we;
      r_d_err    <= d_gnt && !d_we && w_d_mis;
      if (d_gnt && !d_we)
        r_d_rdata <= w_d_mis ? '0 : ram_rdata;
    end
  end

  // Fetch return: capture RAM word for one cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_i_rvalid <= 1'b0;
      r_i_rdata  <= '0;
    end else begin
      r_i_rvalid <= i_gnt;
      if (i_gnt)
        r_i_rdata <= ram_rdata;
    end
  end

endmodule

// File: tb/tb_ram_arbiter.sv
// Randomized bench for ram_arbiter with a behavioural reference model.
// Directed scenarios pin the model with literal expectations.
module tb_ram_arbiter;
  import ram_arbiter_pkg::*;

  localparam int LIMIT = 3;
  localparam int NW    = 1 << (RAM_AW - 2);

  logic      clk = 1'b0;
  logic      rst_n;
  logic      d_req, d_we, i_req;
  RamAddress d_addr, i_addr;
  Word       d_wdata;
  logic      d_gnt, d_rvalid, d_err, i_gnt, i_rvalid, ram_we;
  Word       d_rdata, i_rdata, ram_wdata, ram_rdata;
  RamAddress ram_addr;

  Word tb_mem [NW];
  Word sh_mem [NW];

  int n_chk = 0;
  int n_err = 0;

  // model state
  int   m_starve;
  logic m_d_rv, m_d_err, m_i_rv;
  Word  m_d_rd, m_i_rd;
  logic last_dg, last_ig;

  ram_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .rst_n(rst_n),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata), .d_err(d_err),
    .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt),
    .i_rvalid(i_rvalid), .i_rdata(i_rdata),
    .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata)
  );

  always #5 clk = ~clk;

  // the external RAM
  assign ram_rdata = tb_mem[ram_addr[RAM_AW-1:2]];
  always @(posedge clk)
    if (ram_we) tb_mem[ram_addr[RAM_AW-1:2]] <= ram_wdata;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic mis(RamAddress a);
    return a[1:0] != 2'b00;
  endfunction

  // fetch wins if alone, or once it has been denied LIMIT cycles in a row
  function automatic logic exp_ig();
    return rst_n && i_req && (!d_req || m_starve >= LIMIT);
  endfunction

  function automatic logic exp_dg();
    return rst_n && d_req && !(i_req && (!d_req || m_starve >= LIMIT));
  endfunction

  // model update on clock edge / async reset
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_starve = 0;
      m_d_rv = 0; m_d_err = 0; m_d_rd = '0;
      m_i_rv = 0; m_i_rd = '0;
    end else begin
      logic g_d, g_i;
      g_d = exp_dg();
      g_i = exp_ig();
      if (i_req && !g_i) m_starve = (m_starve >= LIMIT) ? LIMIT : m_starve + 1;
      else m_starve = 0;
      m_d_rv = g_d && !d_we;
      m_d_err = g_d && !d_we && mis(d_addr);
      if (g_d && !d_we)
        m_d_rd = mis(d_addr) ? '0 : sh_mem[d_addr / 4];
      if (g_d && d_we && !mis(d_addr))
        sh_mem[d_addr / 4] = d_wdata;
      m_i_rv = g_i;
      if (g_i) m_i_rd = sh_mem[i_addr / 4];
    end
  end

  // compare DUT against model every cycle, away from the edge
  always @(negedge clk) begin
    logic g_d, g_i;
    RamAddress ea;
    g_d = exp_dg();
    g_i = exp_ig();
    ea = g_d ? d_addr : (g_i ? i_addr : '0);
    chk("d_gnt", 32'(d_gnt), 32'(g_d));
    chk("i_gnt", 32'(i_gnt), 32'(g_i));
    chk("ram_we", 32'(ram_we), 32'(g_d && d_we && !mis(d_addr)));
    chk("ram_addr", 32'(ram_addr), 32'(ea));
    chk("ram_wdata", ram_wdata, d_wdata);
    chk("d_rvalid", 32'(d_rvalid), 32'(m_d_rv));
    chk("d_rdata", d_rdata, m_d_rd);
    chk("d_err", 32'(d_err),
        32'((g_d && d_we && mis(d_addr)) || (m_d_rv && m_d_err)));
    chk("i_rvalid", 32'(i_rvalid), 32'(m_i_rv));
    chk("i_rdata", i_rdata, m_i_rd);
    last_dg = g_d;
    last_ig = g_i;
  end

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int k = 0; k < NW; k++) begin
      tb_mem[k] = $urandom;
      sh_mem[k] = tb_mem[k];
    end
    tb_mem[4] = 32'd7; sh_mem[4] = 32'd7;
    rst_n = 0;
    d_req = 1; d_we = 0; d_addr = 12'h020; d_wdata = 32'h0;
    i_req = 1; i_addr = 12'h010;

    // reset state with both requests asserted
    @(negedge clk);
    chk("rst d_gnt", 32'(d_gnt), 0);
    chk("rst i_gnt", 32'(i_gnt), 0);
    chk("rst ram_we", 32'(ram_we), 0);
    chk("rst rvalid", 32'({d_rvalid, i_rvalid}), 0);
    chk("rst rdata", d_rdata | i_rdata, 0);
    nxt();
    rst_n = 1; d_req = 0; i_req = 0;
    nxt();

    // lone fetch of 0x10
    i_req = 1; i_addr = 12'h010;
    @(negedge clk);
    chk("fetch gnt", 32'(i_gnt), 1);
    nxt();
    i_req = 0;
    @(negedge clk);
    chk("fetch rvalid", 32'(i_rvalid), 1);
    chk("fetch rdata", i_rdata, 7);
    nxt();

    // write 5 to 0x20 then read back
    d_req = 1; d_we = 1; d_addr = 12'h020; d_wdata = 32'd5;
    @(negedge clk);
    chk("wr ram_we", 32'(ram_we), 1);
    nxt();
    d_we = 0; d_wdata = 32'd0;
    @(negedge clk);
    chk("rd no ram_we", 32'(ram_we), 0);
    chk("wr no rvalid", 32'(d_rvalid), 0);
    nxt();
    d_req = 0;
    @(negedge clk);
    chk("rd rvalid", 32'(d_rvalid), 1);
    chk("rd rdata", d_rdata, 5);
    nxt();

    // misaligned write to 0x22
    d_req = 1; d_we = 1; d_addr = 12'h022; d_wdata = 32'd9;
    @(negedge clk);
    chk("mis gnt", 32'(d_gnt), 1);
    chk("mis err", 32'(d_err), 1);
    chk("mis ram_we", 32'(ram_we), 0);
    nxt();
    d_req = 0; d_we = 0;
    @(negedge clk);
    chk("mis ram kept", tb_mem[8], 5);
    nxt();

    // reset the cycle after a read grant
    d_req = 1; d_we = 0; d_addr = 12'h020;
    @(negedge clk);
    chk("pre-rst gnt", 32'(d_gnt), 1);
    nxt();
    d_req = 0;
    rst_n = 0;
    #1;
    chk("rst rvalid drop", 32'(d_rvalid), 0);
    chk("rst rdata drop", d_rdata, 0);
    nxt();

    // contention pattern d,d,d,i from fresh state after release
    rst_n = 1;
    d_req = 1; d_we = 0; d_addr = 12'h020;
    i_req = 1; i_addr = 12'h010;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      chk("pat i_gnt", 32'(i_gnt), 32'((k % 4) == 3));
      chk("pat d_gnt", 32'(d_gnt), 32'((k % 4) != 3));
      nxt();
    end
    d_req = 0; i_req = 0;
    nxt();

    // randomized traffic honouring the hold-until-grant rule
    for (int c = 0; c < 3000; c++) begin
      if (!(d_req && !last_dg)) begin
        d_req = ($urandom % 3) != 0;
        d_we = $urandom % 2;
        d_addr = RamAddress'((($urandom % 16) << 2)
                 | ((($urandom % 8) == 0) ? ($urandom % 3 + 1) : 0));
        d_wdata = $urandom;
      end
      if (!(i_req && !last_ig)) begin
        i_req = ($urandom % 3) != 0;
        i_addr = RamAddress'(($urandom % 16) << 2);
      end
      nxt();
    end
    d_req = 0; i_req = 0;
    nxt();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/ram_arbiter.md
RAM_ARBITER -- requirements
Module: ram_arbiter

Interface
REQ-001 Parameter STARVE_LIMIT, default 3: consecutive denied instruction-port cycles before the instruction port is forced to win.
REQ-002 clk  input  1  system clock; all state updates on posedge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 d_req  input  1  data port request; held with d_we/d_addr/d_wdata stable until d_gnt.
REQ-005 d_we  input  1  data port write (1) / read (0).
REQ-006 d_addr  input  RamAddress  data port byte address.
REQ-007 d_wdata  input  Word  data port store value.
REQ-008 d_gnt  output  1  data request accepted this cycle.
REQ-009 d_rvalid  output  1  one-cycle pulse: d_rdata/d_err valid for the previously granted data read.
REQ-010 d_rdata  output  Word  registered data read result.
REQ-011 d_err  output  1  qualified by d_rvalid or by d_gnt on writes: misaligned access.
REQ-012 i_req  input  1  instruction fetch request; i_addr held stable until i_gnt.
REQ-013 i_addr  input  RamAddress  fetch byte address.
REQ-014 i_gnt  output  1  fetch request accepted this cycle.
REQ-015 i_rvalid  output  1  one-cycle pulse: i_rdata valid.
REQ-016 i_rdata  output  Word  registered fetched word.
REQ-017 ram_we, ram_addr, ram_wdata  output  1/RamAddress/Word  drive the single-port RAM.
REQ-018 ram_rdata  input  Word  combinational RAM read port.

Function
REQ-019 At most one of d_gnt, i_gnt SHALL be high per cycle; grants are combinational from current requests and state.
REQ-020 FSM states DATA_PRI and INSTR_PRI: in DATA_PRI, d_req wins over i_req; in INSTR_PRI, i_req wins.
REQ-021 Starvation counter SHALL increment (saturating at STARVE_LIMIT) on each posedge with i_req && !i_gnt, and clear on i_gnt or !i_req.
REQ-022 FSM SHALL move DATA_PRI -> INSTR_PRI on the posedge where the counter reaches STARVE_LIMIT, and INSTR_PRI -> DATA_PRI on the posedge of any i_gnt or when i_req drops.
REQ-023 A lone requester SHALL be granted in the same cycle, regardless of state.
REQ-024 ram_addr SHALL equal the granted port's address; when idle it SHALL hold 0; ram_wdata SHALL equal d_wdata.
REQ-025 ram_we SHALL be d_gnt && d_we && aligned; a write commits at the posedge ending the grant cycle.
REQ-026 On a read grant, ram_rdata SHALL be captured at that posedge into the port's rdata register; the port's rvalid SHALL be high for exactly the following cycle.
REQ-027 Writes SHALL NOT pulse d_rvalid; d_rdata SHALL hold its previous value across writes.
REQ-028 d_addr[1:0] != 0 is misaligned: grant still given, ram_we suppressed, d_err asserted with d_gnt (write) or with d_rvalid (read, d_rdata = 0); the fetch port does not check alignment.
REQ-029 Back-to-back grants to the same port SHALL be supported every cycle (rvalid high continuously).
REQ-030 Simultaneous d_req and i_req with counter at STARVE_LIMIT-1 in DATA_PRI: data wins this cycle, fetch wins next cycle.

Reset
REQ-031 On rst_n low, asynchronously: FSM = DATA_PRI, counter = 0, d_rvalid = i_rvalid = 0, d_rdata = i_rdata = 0, d_err = 0.
REQ-032 While rst_n is low, d_gnt, i_gnt and ram_we SHALL be 0; a reset mid-transaction drops any pending rvalid.

Structure
REQ-033 RamAddress, Word and the word-address/byte-size macros SHALL come from the shared types package; the FSM state enum SHALL be added there.
REQ-034 No sub-module; the ram is instantiated by the enclosing top level and connected via ram_* ports.

Verification
REQ-035 Lone fetch i_addr=0x10 with RAM[0x10]=7 -> i_gnt same cycle, i_rvalid next cycle with i_rdata=7.
REQ-036 Data write d_addr=0x20, d_wdata=5, then read 0x20 -> ram_we once, d_rvalid with d_rdata=5, no d_rvalid on the write.
REQ-037 Both ports requesting continuously, STARVE_LIMIT=3 -> grant pattern d,d,d,i repeating; i_gnt never absent for more than 3 cycles.
REQ-038 Misaligned write d_addr=0x22 -> d_gnt and d_err high, ram_we low, RAM unchanged.
REQ-039 rst_n asserted the cycle after a read grant -> rvalid/rdata cleared immediately, FSM DATA_PRI, counter 0 after release.
